// File: rtl/cover_toggle_collector.sv
// Toggle-coverage collector: records first hits and streams newly hit cover indices one per cycle.
// Build option: COVER_DEDUP_EN reports each point once per reset/clear epoch; otherwise every strobe is re-queued.
module cover_toggle_collector #(
    parameter int unsigned WIDTH       = 65,
    parameter int unsigned COVER_INDEX = 0,
    parameter int unsigned COVER_TOTAL = 8744,
    parameter int unsigned IDX_W       = 64
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [WIDTH-1:0]               valid,
    input  logic                           clear,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [IDX_W-1:0]               out_index,
    output logic [$clog2(WIDTH+1)-1:0]     hit_count,
    output logic                           busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (WIDTH < 1 || COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_cfg
        $error("cover_toggle_collector: cover range exceeds COVER_TOTAL or WIDTH is zero");
    end

    logic [WIDTH-1:0] hit;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] hit_eff;
    logic [WIDTH-1:0] hit_nxt;
    logic [WIDTH-1:0] new_pts;
    logic [WIDTH-1:0] grant;
    logic [WIDTH-1:0] pending_nxt;
    logic [SEL_W-1:0] sel;
    logic [CNT_W-1:0] count_nxt;
    logic             slot_free;
    logic             out_valid_nxt;
    logic [IDX_W-1:0] out_index_nxt;

    assign hit_eff = clear ? '0 : hit;
    assign hit_nxt = hit_eff | valid;

`ifdef COVER_DEDUP_EN
    assign new_pts = valid & ~hit_eff;
`else
    assign new_pts = valid;
`endif

    // Lowest pending bit as a one-hot grant.
    assign grant     = pending & (~pending + WIDTH'(1));
    assign slot_free = !out_valid || out_ready;
    assign busy      = out_valid || (|pending);

    // Encode the grant and count distinct hits.
    always_comb begin
        sel       = '0;
        count_nxt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (grant[i]) begin
                sel = sel | SEL_W'(i);
            end
            count_nxt = count_nxt + CNT_W'(hit_nxt[i]);
        end
    end

    // Drain one pending point into the output slot when it is free.
    always_comb begin
        pending_nxt   = pending | new_pts;
        out_valid_nxt = out_valid;
        out_index_nxt = out_index;
        if (slot_free) begin
            if (|pending) begin
                out_valid_nxt = 1'b1;
                out_index_nxt = IDX_W'(COVER_INDEX) + IDX_W'(sel);
                pending_nxt   = (pending & ~grant) | new_pts;
            end else begin
                out_valid_nxt = 1'b0;
                pending_nxt   = new_pts;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            hit       <= '0;
            pending   <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            hit_count <= '0;
        end else begin
            hit       <= hit_nxt;
            pending   <= pending_nxt;
            out_valid <= out_valid_nxt;
            out_index <= out_index_nxt;
            hit_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Bench for cover_toggle_collector: vector table plus hand sequences, reports checked through a scoreboard queue.
module tb_cover_toggle_collector;

    localparam int unsigned WIDTH       = 65;
    localparam int unsigned COVER_INDEX = 100;
    localparam int unsigned COVER_TOTAL = 8744;
    localparam int unsigned IDX_W       = 64;
    localparam int unsigned CW          = $clog2(WIDTH + 1);
    localparam int          NV          = 7;

    logic              clock = 1'b0;
    logic              reset;
    logic [WIDTH-1:0]  valid;
    logic              clear;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_index;
    logic [CW-1:0]     hit_count;
    logic              busy;

    cover_toggle_collector #(
        .WIDTH       (WIDTH),
        .COVER_INDEX (COVER_INDEX),
        .COVER_TOTAL (COVER_TOTAL),
        .IDX_W       (IDX_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .valid     (valid),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .hit_count (hit_count),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [WIDTH-1:0]  strobe;
        logic              clr;
        logic [7:0]        hold;
        logic [7:0]        stall;
        logic [7:0]        n_exp;
        logic [3:0][15:0]  exp_idx;
        logic [7:0]        hits;
    } vec_t;

    vec_t        vecs [NV];
    logic [63:0] exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        stall_prev = 1'b0;
    logic [63:0] stall_idx  = '0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    function automatic logic [WIDTH-1:0] b(input int unsigned i);
        return WIDTH'(1) << i;
    endfunction

    function automatic vec_t mkv(input logic [WIDTH-1:0] s, input logic c, input int h, input int st,
                                 input int n, input int e0, input int e1, input int e2, input int e3,
                                 input int hits);
        vec_t v;
        v.strobe     = s;
        v.clr        = c;
        v.hold       = 8'(h);
        v.stall      = 8'(st);
        v.n_exp      = 8'(n);
        v.exp_idx[0] = 16'(e0);
        v.exp_idx[1] = 16'(e1);
        v.exp_idx[2] = 16'(e2);
        v.exp_idx[3] = 16'(e3);
        v.hits       = 8'(hits);
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        valid     = '0;
        clear     = 1'b0;
        out_ready = 1'b1;
        tick();
        exp_q.delete();
        reset = 1'b1;
    endtask

    task automatic drain();
        int k;
        valid     = '0;
        clear     = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 300) begin
            tick();
            k++;
        end
        repeat (3) tick();
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        chk("drain_busy", 64'(busy), 64'd0);
    endtask

    // Transfer monitor: pops the scoreboard and checks output stability under stall.
    always @(negedge clock) begin
        if (!reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_index", out_index, stall_idx);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_report: got index %0d, expected no report", out_index);
                end else begin
                    chk("report_index", out_index, exp_q.pop_front());
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_idx  = out_index;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mkv(b(5), 1'b0, 1, 0, 1, 105, 0, 0, 0, 1);
        vecs[1] = mkv(b(64) | b(0) | b(31), 1'b0, 1, 0, 3, 100, 131, 164, 0, 3);
`ifdef COVER_DEDUP_EN
        vecs[2] = mkv(b(2), 1'b0, 4, 0, 1, 102, 0, 0, 0, 1);
        vecs[4] = mkv(b(64), 1'b0, 2, 0, 1, 164, 0, 0, 0, 1);
`else
        vecs[2] = mkv(b(2), 1'b0, 4, 0, 4, 102, 102, 102, 102, 1);
        vecs[4] = mkv(b(64), 1'b0, 2, 0, 2, 164, 164, 0, 0, 1);
`endif
        vecs[3] = mkv(b(3) | b(7), 1'b0, 1, 10, 2, 103, 107, 0, 0, 2);
        vecs[5] = mkv(b(10), 1'b1, 1, 0, 1, 110, 0, 0, 0, 1);
        vecs[6] = mkv(b(0) | b(1) | b(2) | b(3), 1'b0, 1, 3, 4, 100, 101, 102, 103, 4);

        // Reset state and single-strobe latency.
        do_reset();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_index", out_index, 64'd0);
        chk("rst_hits", 64'(hit_count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        exp_q.push_back(64'd105);
        valid = b(5);
        tick();
        valid = '0;
        chk("lat0_valid", 64'(out_valid), 64'd0);
        chk("lat0_busy", 64'(busy), 64'd1);
        chk("lat0_hits", 64'(hit_count), 64'd1);
        tick();
        chk("lat1_valid", 64'(out_valid), 64'd1);
        chk("lat1_index", out_index, 64'd105);
        tick();
        chk("lat2_valid", 64'(out_valid), 64'd0);
        chk("lat2_busy", 64'(busy), 64'd0);
        drain();

        for (int v = 0; v < NV; v++) begin
            do_reset();
            for (int k = 0; k < int'(vecs[v].n_exp); k++) exp_q.push_back(64'(vecs[v].exp_idx[k]));
            valid     = vecs[v].strobe;
            clear     = vecs[v].clr;
            out_ready = (vecs[v].stall == 8'd0);
            repeat (int'(vecs[v].hold)) tick();
            valid = '0;
            clear = 1'b0;
            repeat (int'(vecs[v].stall)) tick();
            drain();
            chk($sformatf("vec%0d_hits", v), 64'(hit_count), 64'(vecs[v].hits));
        end

        // A bit re-strobed while pending behind a stalled report coalesces.
        do_reset();
        exp_q.push_back(64'd101);
        exp_q.push_back(64'd102);
        out_ready = 1'b0;
        valid = b(1);
        tick();
        valid = b(2);
        repeat (4) tick();
        drain();
        chk("coal_hits", 64'(hit_count), 64'd2);

        // Repeated strobes of one point, then clear with the same point strobed.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c == 0 || c == 5 || c == 9) begin
                valid = b(2);
`ifdef COVER_DEDUP_EN
                if (c == 0) exp_q.push_back(64'd102);
`else
                exp_q.push_back(64'd102);
`endif
            end else begin
                valid = '0;
            end
            tick();
        end
        drain();
        chk("dd_hits", 64'(hit_count), 64'd1);
        exp_q.push_back(64'd102);
        valid = b(2);
        clear = 1'b1;
        tick();
        valid = '0;
        clear = 1'b0;
        chk("dd_clr_hits", 64'(hit_count), 64'd1);
        drain();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_only_hits", 64'(hit_count), 64'd0);

        // Clear leaves pending points and the output slot intact.
        exp_q.push_back(64'd104);
        exp_q.push_back(64'd106);
        out_ready = 1'b0;
        valid = b(4) | b(6);
        tick();
        valid = '0;
        clear = 1'b1;
        repeat (2) tick();
        clear = 1'b0;
        chk("clr_keep_hits", 64'(hit_count), 64'd0);
        chk("clr_keep_busy", 64'(busy), 64'd1);
        drain();

        // Reset in the middle of a drain discards everything.
        do_reset();
        out_ready = 1'b0;
        valid = '0;
        for (int i = 10; i < 20; i++) valid = valid | b(i);
        tick();
        valid = '0;
        repeat (3) tick();
        chk("mid_busy_pre", 64'(busy), 64'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mid_valid", 64'(out_valid), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_hits", 64'(hit_count), 64'd0);
        out_ready = 1'b1;
        repeat (10) tick();
        chk("mid_busy_post", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
